// File: rtl/upsp_arb_pkg.sv
// Shared types and width helpers for the upsampler write-back arbiter.
package upsp_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DEFAULT_N_PARALLEL = 4;

  // Width of an engine index; kept at 1 so a degenerate single-engine build still has a legal vector.
  function automatic int src_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/upsp_wb_arbiter_rr_pick.sv
// Round-robin priority selector: first request at or cyclically after i_ptr.
module rr_pick
  import upsp_arb_pkg::*;
#(
  parameter int N     = DEFAULT_N_PARALLEL,
  parameter int SRC_W = src_width(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [SRC_W-1:0] i_ptr,
  output logic [SRC_W-1:0] o_idx,
  output logic             o_found
);

  logic [N-1:0]     w_rot;
  logic [SRC_W-1:0] w_off;
  logic [SRC_W:0]   w_sum;

  // Rotate so bit 0 is the engine at i_ptr, find the lowest set bit, then rotate the offset back.
  always_comb begin
    w_rot   = N'({i_req, i_req} >> i_ptr);
    w_off   = '0;
    o_found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off   = SRC_W'(k);
        o_found = 1'b1;
      end
    end
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= (SRC_W + 1)'(N)) begin
      w_sum = w_sum - (SRC_W + 1)'(N);
    end
    o_idx = w_sum[SRC_W-1:0];
  end

endmodule

// File: rtl/upsp_wb_arbiter.sv
// Round-robin write-back arbiter sharing the access_control upsampler write channel
// between N_PARALLEL engines, with bounded bursts and one registered output stage.
module upsp_wb_arbiter
  import upsp_arb_pkg::*;
#(
  parameter int N_PARALLEL         = DEFAULT_N_PARALLEL,
  parameter int UPSP_WRTDATA_WIDTH = 32,
  parameter int BURST_LEN          = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [N_PARALLEL-1:0]                    upsp_wvalid,
  input  logic [N_PARALLEL*UPSP_WRTDATA_WIDTH-1:0] upsp_wdata,
  input  logic [N_PARALLEL-1:0]                    upsp_wlast,
  output logic [N_PARALLEL-1:0]                    upsp_wready,
  output logic                                     ac_wvalid,
  output logic [UPSP_WRTDATA_WIDTH-1:0]            ac_wdata,
  output logic [$clog2(N_PARALLEL)-1:0]            ac_wsrc,
  input  logic                                     ac_wready,
  input  logic                                     ac_processing,
  output logic                                     arb_busy
);

  localparam int SRC_W = src_width(N_PARALLEL);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  arb_state_e                    r_state;
  arb_state_e                    w_state_nxt;
  logic [SRC_W-1:0]              r_gnt_idx;
  logic [SRC_W-1:0]              r_rr_ptr;
  logic [CNT_W-1:0]              r_beat_cnt;
  logic [SRC_W-1:0]              w_pick_idx;
  logic                          w_pick_found;
  logic [CNT_W-1:0]              w_cnt_inc;
  logic [SRC_W-1:0]              w_ptr_nxt;
  logic                          w_out_free;
  logic                          w_start;
  logic                          w_accept;
  logic                          w_release;
  logic [UPSP_WRTDATA_WIDTH-1:0] w_lane [N_PARALLEL];

  for (genvar g = 0; g < N_PARALLEL; g++) begin : g_lane
    assign w_lane[g] = upsp_wdata[g*UPSP_WRTDATA_WIDTH +: UPSP_WRTDATA_WIDTH];
  end

  rr_pick #(
    .N     (N_PARALLEL),
    .SRC_W (SRC_W)
  ) u_rr_pick (
    .i_req   (upsp_wvalid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  // The output stage can take a beat when empty or being drained this cycle.
  assign w_out_free = ~ac_wvalid | ac_wready;
  assign w_cnt_inc  = r_beat_cnt + CNT_W'(1);
  assign w_ptr_nxt  = (r_gnt_idx == SRC_W'(N_PARALLEL - 1)) ? '0 : r_gnt_idx + SRC_W'(1);
  assign arb_busy   = (r_state == GRANT) | ac_wvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    upsp_wready = '0;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        if (ac_processing && w_pick_found) begin
          w_start     = 1'b1;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        upsp_wready[r_gnt_idx] = w_out_free;
        w_accept  = upsp_wvalid[r_gnt_idx] & w_out_free;
        w_release = w_accept & (upsp_wlast[r_gnt_idx] | (w_cnt_inc == CNT_W'(BURST_LEN)));
        if (w_release) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_idx  <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (w_start) begin
        r_gnt_idx  <= w_pick_idx;
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        r_beat_cnt <= w_cnt_inc;
      end
      if (w_release) begin
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  // A reload in the same cycle as a take keeps ac_wvalid high with no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_wvalid <= 1'b0;
      ac_wdata  <= '0;
      ac_wsrc   <= '0;
    end else if (w_accept) begin
      ac_wvalid <= 1'b1;
      ac_wdata  <= w_lane[r_gnt_idx];
      ac_wsrc   <= r_gnt_idx;
    end else if (ac_wready) begin
      ac_wvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_upsp_wb_arbiter.sv
// Directed self-checking bench for upsp_wb_arbiter: engines are modelled as beat
// counters, delivered output beats are logged and compared against hand-computed sequences.
module tb_upsp_wb_arbiter;

  localparam int NP = 4;
  localparam int W  = 32;
  localparam int BL = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     upspWvalid;
  logic [NP*W-1:0]   upspWdata;
  logic [NP-1:0]     upspWlast;
  logic [NP-1:0]     upspWready;
  logic              acWvalid;
  logic [W-1:0]      acWdata;
  logic [1:0]        acWsrc;
  logic              acWready;
  logic              acProcessing;
  logic              arbBusy;

  int          remaining [NP];
  int          sent      [NP];
  int          lastAt    [NP];
  logic [31:0] baseVal   [NP];

  int          logSrc[$];
  logic [31:0] logData[$];
  int          logCyc[$];

  int          cyc = 0;
  int          checkCount = 0;
  int          failCount = 0;
  int          t;

  logic [NP-1:0] sampWready;
  logic          sampValid;
  logic [W-1:0]  sampData;
  logic [1:0]    sampSrc;
  logic          sampBusy;

  upsp_wb_arbiter #(
    .N_PARALLEL         (NP),
    .UPSP_WRTDATA_WIDTH (W),
    .BURST_LEN          (BL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .upsp_wvalid   (upspWvalid),
    .upsp_wdata    (upspWdata),
    .upsp_wlast    (upspWlast),
    .upsp_wready   (upspWready),
    .ac_wvalid     (acWvalid),
    .ac_wdata      (acWdata),
    .ac_wsrc       (acWsrc),
    .ac_wready     (acWready),
    .ac_processing (acProcessing),
    .arb_busy      (arbBusy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time bound, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic driveEngines();
    for (int i = 0; i < NP; i++) begin
      upspWvalid[i]          = (remaining[i] > 0);
      upspWlast[i]           = (lastAt[i] != 0) && (sent[i] + 1 == lastAt[i]);
      upspWdata[i*W +: W]    = baseVal[i] + 32'(sent[i]);
    end
  endtask

  task automatic loadEngine(input int idx, input int count, input int last, input logic [31:0] base);
    remaining[idx] = count;
    sent[idx]      = 0;
    lastAt[idx]    = last;
    baseVal[idx]   = base;
    driveEngines();
  endtask

  task automatic clearEngines();
    for (int i = 0; i < NP; i++) begin
      remaining[i] = 0;
      sent[i]      = 0;
      lastAt[i]    = 0;
      baseVal[i]   = 32'h0;
    end
    driveEngines();
  endtask

  // One clock cycle: sample mid-cycle, log taken beats, then advance engines after the edge.
  task automatic applyStimulus();
    logic [NP-1:0] acc;
    @(negedge clk);
    cyc++;
    sampWready = upspWready;
    sampValid  = acWvalid;
    sampData   = acWdata;
    sampSrc    = acWsrc;
    sampBusy   = arbBusy;
    checkOutput("wready_onehot0", 64'($onehot0(upspWready)), 64'd1);
    if (acWvalid && acWready) begin
      logSrc.push_back(int'(acWsrc));
      logData.push_back(acWdata);
      logCyc.push_back(cyc);
    end
    acc = upspWvalid & upspWready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (acc[i]) begin
        sent[i]++;
        remaining[i]--;
      end
    end
    driveEngines();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic clearLog();
    logSrc.delete();
    logData.delete();
    logCyc.delete();
  endtask

  task automatic doReset();
    rst_n        = 1'b0;
    acWready     = 1'b1;
    acProcessing = 1'b1;
    clearEngines();
    runCycles(2);
    rst_n = 1'b1;
    clearLog();
  endtask

  task automatic checkLog(input string tag, input int k, input int expSrc, input logic [31:0] expData);
    int          s;
    logic [31:0] d;
    s = (k < logSrc.size()) ? logSrc[k] : -1;
    d = (k < logData.size()) ? logData[k] : 32'hDEADBEEF;
    checkOutput($sformatf("%s[%0d].src", tag, k), 64'(s), 64'(expSrc));
    checkOutput($sformatf("%s[%0d].data", tag, k), 64'(d), 64'(expData));
  endtask

  task automatic checkLogCyc(input string tag, input int k, input int expCyc);
    int c;
    c = (k < logCyc.size()) ? logCyc[k] : -1;
    checkOutput($sformatf("%s[%0d].cycle", tag, k), 64'(c), 64'(expCyc));
  endtask

  initial begin
    logic [31:0] fb [NP];
    int          src;
    rst_n        = 1'b1;
    acWready     = 1'b1;
    acProcessing = 1'b1;
    clearEngines();

    // Reset state, with a request pending that must not be granted
    #1 rst_n = 1'b0;
    loadEngine(2, 3, 3, 32'hA1);
    runCycles(2);
    checkOutput("reset_wready", 64'(sampWready), 64'h0);
    checkOutput("reset_wvalid", 64'(sampValid), 64'h0);
    checkOutput("reset_wdata", 64'(sampData), 64'h0);
    checkOutput("reset_wsrc", 64'(sampSrc), 64'h0);
    checkOutput("reset_busy", 64'(sampBusy), 64'h0);

    // Single requester: engine 2 sends A1..A3, wlast on the third
    $display("[TB] single requester");
    doReset();
    loadEngine(2, 3, 3, 32'hA1);
    t = cyc + 1;
    applyStimulus();
    checkOutput("single_wready_t0", 64'(sampWready), 64'h0);
    applyStimulus();
    checkOutput("single_wready_t1", 64'(sampWready), 64'b0100);
    runCycles(6);
    checkOutput("single_count", 64'(logSrc.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      checkLog("single", k, 2, 32'hA1 + 32'(k));
      checkLogCyc("single", k, t + 2 + k);
    end
    checkOutput("single_busy_end", 64'(sampBusy), 64'h0);
    checkOutput("single_valid_end", 64'(sampValid), 64'h0);

    // Fairness: all engines request continuously, no wlast
    $display("[TB] fairness");
    doReset();
    fb[0] = 32'h100; fb[1] = 32'h200; fb[2] = 32'h300; fb[3] = 32'h400;
    loadEngine(0, 8, 0, fb[0]);
    loadEngine(1, 4, 0, fb[1]);
    loadEngine(2, 4, 0, fb[2]);
    loadEngine(3, 4, 0, fb[3]);
    t = cyc + 1;
    runCycles(30);
    checkOutput("fair_count", 64'(logSrc.size()), 64'd20);
    for (int k = 0; k < 20; k++) begin
      src = (k / 4) % 4;
      checkLog("fair", k, src, fb[src] + ((k >= 16) ? 32'd4 : 32'd0) + 32'(k % 4));
      checkLogCyc("fair", k, t + 2 + k + k / 4);
    end

    // Backpressure: sink stalls for 5 cycles while beat 0x51 is held
    $display("[TB] backpressure");
    doReset();
    loadEngine(0, 8, 0, 32'h50);
    runCycles(3);
    acWready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      checkOutput($sformatf("bp_wready[%0d]", k), 64'(sampWready), 64'h0);
      checkOutput($sformatf("bp_valid[%0d]", k), 64'(sampValid), 64'h1);
      checkOutput($sformatf("bp_data[%0d]", k), 64'(sampData), 64'h51);
    end
    acWready = 1'b1;
    runCycles(15);
    checkOutput("bp_count", 64'(logSrc.size()), 64'd8);
    for (int k = 0; k < 8; k++) checkLog("bp", k, 0, 32'h50 + 32'(k));

    // Early wlast: engine 1 ends after 2 beats, next grant goes to engine 2, then wraps to 0
    $display("[TB] early wlast");
    doReset();
    loadEngine(1, 2, 2, 32'h10);
    t = cyc + 1;
    applyStimulus();
    loadEngine(0, 1, 1, 32'h20);
    loadEngine(2, 1, 1, 32'h30);
    runCycles(12);
    checkOutput("wlast_count", 64'(logSrc.size()), 64'd4);
    checkLog("wlast", 0, 1, 32'h10);
    checkLog("wlast", 1, 1, 32'h11);
    checkLog("wlast", 2, 2, 32'h30);
    checkLog("wlast", 3, 0, 32'h20);
    checkLogCyc("wlast", 1, t + 3);
    checkLogCyc("wlast", 2, t + 5);
    checkLogCyc("wlast", 3, t + 7);

    // Processing gate: drop during beat 2 of engine 3, engine 0 waits until it rises
    $display("[TB] processing gate");
    doReset();
    loadEngine(3, 4, 0, 32'h70);
    runCycles(2);
    acProcessing = 1'b0;
    loadEngine(0, 4, 0, 32'h80);
    runCycles(9);
    checkOutput("gate_count_low", 64'(logSrc.size()), 64'd4);
    for (int k = 0; k < 4; k++) checkLog("gate", k, 3, 32'h70 + 32'(k));
    checkOutput("gate_wready_low", 64'(sampWready), 64'h0);
    checkOutput("gate_busy_low", 64'(sampBusy), 64'h0);
    acProcessing = 1'b1;
    applyStimulus();
    checkOutput("gate_wready_rise0", 64'(sampWready), 64'h0);
    applyStimulus();
    checkOutput("gate_wready_rise1", 64'(sampWready), 64'b0001);
    runCycles(8);
    checkOutput("gate_count_total", 64'(logSrc.size()), 64'd8);
    for (int k = 4; k < 8; k++) checkLog("gate", k, 0, 32'h80 + 32'(k - 4));

    // Reset mid-burst: output register full with engine 2 data, rr pointer at 2
    $display("[TB] reset mid-burst");
    doReset();
    loadEngine(1, 1, 1, 32'h90);
    runCycles(4);
    loadEngine(2, 4, 0, 32'hA0);
    runCycles(3);
    checkOutput("rst_pre_valid", 64'(sampValid), 64'h1);
    checkOutput("rst_pre_src", 64'(sampSrc), 64'h2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", 64'(acWvalid), 64'h0);
    checkOutput("rst_async_data", 64'(acWdata), 64'h0);
    checkOutput("rst_async_src", 64'(acWsrc), 64'h0);
    checkOutput("rst_async_busy", 64'(arbBusy), 64'h0);
    checkOutput("rst_async_wready", 64'(upspWready), 64'h0);
    clearEngines();
    clearLog();
    loadEngine(1, 1, 1, 32'hB0);
    loadEngine(3, 1, 1, 32'hC0);
    runCycles(2);
    rst_n = 1'b1;
    runCycles(8);
    checkOutput("rst_post_count", 64'(logSrc.size()), 64'd2);
    checkLog("rst_post", 0, 1, 32'hB0);
    checkLog("rst_post", 1, 3, 32'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
